// File: rtl/pulse_divider_multi.sv
// pulse_divider_multi: multi-channel programmable tick / divided-clock generator.
// Each channel produces a one-cycle tick (pulse_out) and a ~50% clock enable
// (clk_out). Divisors are loaded through a single shared shadow register over a
// valid/ready port and take effect only at period boundaries.
// Optional feature macro: PULSE_DIV_TICKCNT_EN adds a per-channel 16-bit count
// of pulse_out cycles on port tick_cnt.
module pulse_divider_multi #(
    parameter int unsigned  CHANNELS    = 4,
    parameter int unsigned  CNT_W       = 32,
    parameter int unsigned  DEFAULT_DIV = 500_000,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    en,
    input  logic                   sync_clr,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [CNT_W-1:0]       cfg_div,
`ifdef PULSE_DIV_TICKCNT_EN
    output logic [CHANNELS*16-1:0] tick_cnt,
`endif
    output logic [CHANNELS-1:0]    pulse_out,
    output logic [CHANNELS-1:0]    clk_out
);

    localparam int unsigned TICK_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t                cnt_q [CHANNELS];
    cnt_t                cnt_d [CHANNELS];
    cnt_t                div_q [CHANNELS];
    cnt_t                div_d [CHANNELS];
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] clk_q, clk_d;

    cnt_t                sh_div_q, sh_div_d;
    logic [CH_W-1:0]     sh_ch_q, sh_ch_d;
    logic                pend_q, pend_d;
    logic                rdy_q, rdy_d;

    logic                accept_c;
    logic                sh_in_range_c;
    logic                apply_c;
    logic [CHANNELS-1:0] tgt_c;
    logic [CHANNELS-1:0] idle_c;
    logic [CHANNELS-1:0] wrap_c;

`ifdef PULSE_DIV_TICKCNT_EN
    logic [TICK_W-1:0]   tick_q [CHANNELS];
    logic [TICK_W-1:0]   tick_d [CHANNELS];
`endif

    // Per-channel status decode and shadow-apply decision
    always_comb begin
        accept_c      = cfg_valid & rdy_q;
        sh_in_range_c = (32'(sh_ch_q) < CHANNELS);
        tgt_c         = '0;
        idle_c        = '0;
        wrap_c        = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            tgt_c[k]  = sh_in_range_c & (sh_ch_q == CH_W'(k));
            idle_c[k] = ~en[k] | (div_q[k] == '0);
            wrap_c[k] = ~idle_c[k] & (cnt_q[k] == (div_q[k] - cnt_t'(1)));
        end
        // Out-of-range targets are dropped on the edge after accept
        apply_c = pend_q & (sync_clr | ~sh_in_range_c | (|(tgt_c & (idle_c | wrap_c))));
    end

    // Next-state for counters, divisors, outputs and the config shadow
    always_comb begin
        sh_div_d = sh_div_q;
        sh_ch_d  = sh_ch_q;
        pend_d   = pend_q;
        pulse_d  = '0;
        clk_d    = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            cnt_d[k] = cnt_q[k];
            div_d[k] = div_q[k];
        end

        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (apply_c && tgt_c[k]) begin
                div_d[k] = sh_div_q;
            end
            if (sync_clr || idle_c[k]) begin
                cnt_d[k]   = '0;
                pulse_d[k] = 1'b0;
                clk_d[k]   = 1'b0;
            end else if (wrap_c[k]) begin
                // New period starts at cnt=0, high while div_d >= 1
                cnt_d[k]   = '0;
                pulse_d[k] = 1'b1;
                clk_d[k]   = (div_d[k] != '0);
            end else begin
                // High while cnt < ceil(div/2); cnt+1 cannot overflow here
                cnt_d[k]   = cnt_q[k] + cnt_t'(1);
                pulse_d[k] = 1'b0;
                clk_d[k]   = (cnt_d[k] < ((div_q[k] >> 1) + cnt_t'(div_q[k][0])));
            end
        end

        if (apply_c) begin
            pend_d = 1'b0;
        end
        if (accept_c) begin
            sh_div_d = cfg_div;
            sh_ch_d  = cfg_ch;
            pend_d   = 1'b1;
        end
        rdy_d = ~pend_d;
    end

`ifdef PULSE_DIV_TICKCNT_EN
    // Tick counters count cycles where pulse_out is asserted
    always_comb begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (sync_clr) begin
                tick_d[k] = '0;
            end else begin
                tick_d[k] = tick_q[k] + TICK_W'(pulse_d[k]);
            end
        end
    end

    // Pack per-channel tick counters onto the output bus
    always_comb begin
        tick_cnt = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            tick_cnt[k*TICK_W +: TICK_W] = tick_q[k];
        end
    end

    // Tick counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                tick_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                tick_q[k] <= tick_d[k];
            end
        end
    end
`endif

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                cnt_q[k] <= '0;
                div_q[k] <= CNT_W'(DEFAULT_DIV);
            end
            pulse_q  <= '0;
            clk_q    <= '0;
            sh_div_q <= '0;
            sh_ch_q  <= '0;
            pend_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                cnt_q[k] <= cnt_d[k];
                div_q[k] <= div_d[k];
            end
            pulse_q  <= pulse_d;
            clk_q    <= clk_d;
            sh_div_q <= sh_div_d;
            sh_ch_q  <= sh_ch_d;
            pend_q   <= pend_d;
            rdy_q    <= rdy_d;
        end
    end

    assign pulse_out = pulse_q;
    assign clk_out   = clk_q;
    assign cfg_ready = rdy_q;

endmodule
